pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter STAGE, default 8, meaning the number of PWM input channels.
REQ-002 SHALL have parameter DWIDTH, default 8, meaning the width of each measured pulse value.
REQ-003 SHALL have parameter TIMEOUT, default 512, meaning the maximum number of measurement cycles before forced completion.
REQ-004 SHALL have port clkforcounter, input, 1 bit: the single clock; all sampling and counting happens on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request to arm a capture.
REQ-007 SHALL have port pwm_in, input, STAGE bits: PWM pulse inputs, one bit per channel.
REQ-008 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data, out_ch and out_ovf are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the current output word.
REQ-011 SHALL have port out_data, output, DWIDTH bits: measured pulse width in clkforcounter cycles.
REQ-012 SHALL have port out_ch, output, $clog2(STAGE) bits: channel index of out_data.
REQ-013 SHALL have port out_ovf, output, 1 bit: the channel's count saturated.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when the last word is accepted.

Function
REQ-015 SHALL implement the FSM states IDLE, MEASURE and READOUT.
REQ-016 SHALL move IDLE->MEASURE on start=1; the same edge clears all per-channel counts, ovf bits, finished bits and the timeout counter.
REQ-017 SHALL ignore start in MEASURE and READOUT: no clearing and no restart.
REQ-018 In MEASURE, at each edge, SHALL increment channel k's count when pwm_in[k]=1 and finished[k]=0.
REQ-019 SHALL set finished[k] at the first edge where pwm_in[k]=0 and count[k]>0, so only the first high interval is measured.
REQ-020 SHALL measure a channel already high at arm time from the first MEASURE edge.
REQ-021 SHALL, for a pulse high for N sampled edges, report N.
REQ-022 SHALL hold count[k] at 2^DWIDTH-1 once reached; a further high sample sets ovf[k]=1.
REQ-023 SHALL increment the timeout counter every MEASURE cycle.
REQ-024 SHALL move MEASURE->READOUT when all finished bits are 1 or the timeout counter reaches TIMEOUT-1, whichever comes first.
REQ-025 At timeout, a channel that never went high SHALL report 0 with ovf=0, and a channel still high SHALL report its current count.
REQ-026 If all channels finish on the same edge that the timeout fires, SHALL treat this as normal completion with identical results.
REQ-027 In READOUT, SHALL present channels in order 0..STAGE-1 with out_valid=1.
REQ-028 SHALL advance to the next channel only on an edge with out_valid=1 and out_ready=1.
REQ-029 SHALL hold out_data, out_ch and out_ovf stable while out_valid=1 and out_ready=0.
REQ-030 SHALL, on acceptance of channel STAGE-1, pulse done for one cycle, drop out_valid and return to IDLE.
REQ-031 SHALL accept start in the first IDLE cycle after that return.
REQ-032 SHALL drive first out_valid on the edge after MEASURE->READOUT (registered outputs, 1-cycle latency).
REQ-033 SHALL drive out_valid=0 outside READOUT; out_data and out_ovf SHALL be 0 whenever out_valid=0.

Reset
REQ-034 When rst=0 (asynchronous), SHALL force state=IDLE, busy=0, out_valid=0, out_data=0, out_ch=0, out_ovf=0, done=0, and all counts, ovf and finished bits to 0.
REQ-035 When rst is asserted mid-MEASURE or mid-READOUT, SHALL abandon the capture, discard all results and emit no done pulse.
REQ-036 On rst release, SHALL begin operation on the first rising edge with rst=1.

Verification
REQ-037 Channel k driven high for widths {3,10,1,255,0x80,7,20,64} after start, out_ready=1 -> words ch0..ch7 carry those values, ovf=0, done pulses once.
REQ-038 Channel 2 high for 300 cycles, DWIDTH=8 -> ch2 reports 255 with out_ovf=1; other channels are unaffected.
REQ-039 Channel 5 never toggles, others 4-cycle pulses -> READOUT entered at TIMEOUT; ch5=0 ovf=0, others=4.
REQ-040 out_ready held low for 5 cycles at ch3 -> ch3 word held stable for 5 cycles; no word skipped or duplicated.
REQ-041 start pulsed during MEASURE, and rst dropped during READOUT at ch4 -> the extra start has no effect; after reset all outputs are 0, no done pulse occurs, and a new capture works.
REQ-042 pwm_in[0] high when start is asserted, falling 6 edges later, then a second pulse -> ch0 reports 6 and the second pulse is ignored.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures the first high pulse on each PWM channel, then reads the widths out in channel order.
//   clkforcounter       : the single clock; all sampling and counting on its rising edge
//   rst                 : asynchronous active-low reset
//   start               : single-cycle request to arm a capture (honoured only in IDLE)
//   pwm_in[STAGE]       : PWM inputs, one bit per channel
//   busy                : high whenever the block is not IDLE
//   out_valid/out_ready : handshake for the readout words
//   out_data            : measured pulse width in clock cycles (saturating)
//   out_ch              : channel index of out_data
//   out_ovf             : the channel's count saturated
//   done                : one-cycle pulse when the last word is accepted
module pwm_capture #(
    parameter int STAGE   = 8,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 512
) (
    input  logic                     clkforcounter,
    input  logic                     rst,
    input  logic                     start,
    input  logic [STAGE-1:0]         pwm_in,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DWIDTH-1:0]        out_data,
    output logic [$clog2(STAGE)-1:0] out_ch,
    output logic                     out_ovf,
    output logic                     done
);
    localparam int CW = $clog2(STAGE);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DWIDTH-1:0] CMAX = '1;

    typedef enum logic [1:0] {IDLE, MEASURE, READOUT} state_t;

    state_t                          state_q, state_d;
    logic [STAGE-1:0][DWIDTH-1:0]    cnt_q, cnt_d;
    logic [STAGE-1:0]                ovf_q, ovf_d;
    logic [STAGE-1:0]                fin_q, fin_d;
    logic [TW-1:0]                   tmo_q, tmo_d;
    logic [CW-1:0]                   idx_q, idx_d;
    logic                            busy_q, busy_d;
    logic                            out_valid_q, out_valid_d;
    logic [DWIDTH-1:0]               out_data_q, out_data_d;
    logic [CW-1:0]                   out_ch_q, out_ch_d;
    logic                            out_ovf_q, out_ovf_d;
    logic                            done_q, done_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        fin_d       = fin_q;
        tmo_d       = tmo_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_ovf_d   = out_ovf_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                    ovf_d   = '0;
                    fin_d   = '0;
                    tmo_d   = '0;
                    idx_d   = '0;
                end
            end
            MEASURE: begin
                for (int k = 0; k < STAGE; k++) begin
                    if (!fin_q[k]) begin
                        if (pwm_in[k]) begin
                            // saturate; a high sample beyond full scale flags overflow
                            if (cnt_q[k] == CMAX) ovf_d[k] = 1'b1;
                            else cnt_d[k] = cnt_q[k] + 1'b1;
                        end else if (cnt_q[k] != '0) begin
                            // first falling edge after a high interval closes the channel
                            fin_d[k] = 1'b1;
                        end
                    end
                end
                tmo_d = tmo_q + 1'b1;
                if (&fin_d || tmo_q == TW'(TIMEOUT - 1)) state_d = READOUT;
            end
            READOUT: begin
                if (!out_valid_q) begin
                    // first word is registered one edge after entering READOUT
                    out_valid_d = 1'b1;
                    out_data_d  = cnt_q[idx_q];
                    out_ovf_d   = ovf_q[idx_q];
                    out_ch_d    = idx_q;
                end else if (out_ready) begin
                    if (idx_q == CW'(STAGE - 1)) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_ovf_d   = 1'b0;
                        out_ch_d    = '0;
                        done_d      = 1'b1;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        out_data_d = cnt_q[idx_d];
                        out_ovf_d  = ovf_q[idx_d];
                        out_ch_d   = idx_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clkforcounter or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ovf_q       <= '0;
            fin_q       <= '0;
            tmo_q       <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_ovf_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            fin_q       <= fin_d;
            tmo_q       <= tmo_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_ovf_q   <= out_ovf_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_ovf   = out_ovf_q;
    assign done      = done_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized and directed checks of pwm_capture against a transaction-level model.
module tb_pwm_capture;
    localparam int ST = 8, DW = 8, TO = 512, MAXV = 255;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [ST-1:0] pwm_in = '0;
    logic          busy, out_valid, out_ovf, done;
    logic [DW-1:0] out_data;
    logic [2:0]    out_ch;

    int vectors = 0, miscompares = 0;

    pwm_capture #(.STAGE(ST), .DWIDTH(DW), .TIMEOUT(TO)) dut (
        .clkforcounter(clk), .rst(rst_n), .start(start), .pwm_in(pwm_in),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .out_ovf(out_ovf), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: record the sampled inputs of the capture window, derive each channel's
    // first high run from that record, then expect the words in order under the handshake.
    typedef struct packed {logic [DW-1:0] d; logic o; logic [2:0] c;} word_t;
    word_t         exp_q[$];
    bit [ST-1:0]   samp[$];
    bit [ST-1:0]   seen, closed;
    bit            m_cap = 0, m_due = 0, m_rd = 0, m_done = 0;

    function automatic void build();
        for (int k = 0; k < ST; k++) begin
            int n = 0;
            bit stop = 0;
            word_t w;
            for (int i = 0; i < samp.size(); i++) begin
                if (samp[i][k] && !stop) n++;
                else if (n > 0) stop = 1;
            end
            w.d = (n > MAXV) ? DW'(MAXV) : DW'(n);
            w.o = n > MAXV;
            w.c = 3'(k);
            exp_q.push_back(w);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cap = 0; m_due = 0; m_rd = 0; m_done = 0;
            exp_q.delete();
        end else begin
            m_done = 0;
            if (m_rd) begin
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin m_rd = 0; m_done = 1; end
                end
            end else if (m_due) begin
                m_due = 0; m_rd = 1;
            end else if (m_cap) begin
                samp.push_back(pwm_in);
                seen |= pwm_in;
                closed |= seen & ~pwm_in;
                if (&closed || samp.size() == TO) begin build(); m_cap = 0; m_due = 1; end
            end else if (start) begin
                m_cap = 1; samp.delete(); seen = '0; closed = '0;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_cap | m_due | m_rd);
        chk("out_valid", out_valid, m_rd);
        chk("done", done, m_done);
        if (m_rd) begin
            chk("out_data", out_data, exp_q[0].d);
            chk("out_ovf", out_ovf, exp_q[0].o);
            chk("out_ch", out_ch, exp_q[0].c);
        end else begin
            chk("idle_data", out_data, 0);
            chk("idle_ovf", out_ovf, 0);
        end
    end

    int acc_d[ST], acc_o[ST], acc_n;
    always @(posedge clk) if (rst_n && out_valid && out_ready) begin
        acc_d[out_ch] = out_data;
        acc_o[out_ch] = out_ovf;
        acc_n++;
    end

    int dly[ST], wid[ST], dly2[ST], wid2[ST];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_pwm(input int j);
        for (int k = 0; k < ST; k++)
            pwm_in[k] = (j >= dly[k] && j < dly[k] + wid[k]) || (j >= dly2[k] && j < dly2[k] + wid2[k]);
    endtask

    task automatic setall(input int d, input int w);
        for (int k = 0; k < ST; k++) begin dly[k] = d; wid[k] = w; dly2[k] = 0; wid2[k] = 0; end
    endtask

    // j indexes the clock edge relative to the arming edge (j = 0)
    task automatic capture(input int rmode, input bit mid, input bit abort,
                           output int first_v, output int dn, output int held3);
        int stall = 0;
        bit ended = 0;
        first_v = -1; dn = 0; held3 = 0; acc_n = 0;
        for (int j = 0; j < 3000 && !ended; j++) begin
            set_pwm(j);
            start = (j == 0) || (mid && j == 5);
            if (rmode == 2) begin
                out_ready = !(out_valid && out_ch == 3 && stall < 5);
                if (!out_ready) stall++;
            end else out_ready = (rmode == 0) || ($urandom_range(0, 2) != 0);
            step();
            if (out_valid && first_v < 0) first_v = j;
            if (out_valid && out_ch == 3) held3++;
            if (done) begin dn++; ended = 1; end
            if (abort && out_valid && out_ch == 4) begin
                start = 0;
                rst_n = 0;
                for (int i = 0; i < 2; i++) begin step(); if (done) dn++; end
                chk("abort_valid", out_valid, 0);
                chk("abort_data", out_data, 0);
                chk("abort_ch", out_ch, 0);
                chk("abort_busy", busy, 0);
                rst_n = 1;
                step();
                if (done) dn++;
                ended = 1;
            end
        end
        if (!ended) begin
            miscompares++;
            $display("FAIL capture_budget: got no done in 3000 cycles, expected done");
        end
        start = 0; pwm_in = '0; out_ready = 0;
    endtask

    int w37[ST] = '{3, 10, 1, 255, 128, 7, 20, 64};
    int fv, dn, h3;

    initial begin
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_done", done, 0);
        rst_n = 1;
        step();

        setall(1, 0);
        for (int k = 0; k < ST; k++) wid[k] = w37[k];
        capture(0, 0, 0, fv, dn, h3);
        for (int k = 0; k < ST; k++) begin
            chk("widths_data", acc_d[k], w37[k]);
            chk("widths_ovf", acc_o[k], 0);
        end
        chk("widths_done", dn, 1);
        chk("widths_words", acc_n, 8);
        chk("widths_first_valid", fv, 257);

        setall(1, 5);
        wid[2] = 300;
        capture(0, 0, 0, fv, dn, h3);
        chk("sat_data", acc_d[2], 255);
        chk("sat_ovf", acc_o[2], 1);
        chk("sat_other_data", acc_d[0], 5);
        chk("sat_other_ovf", acc_o[0], 0);

        setall(2, 4);
        wid[5] = 0;
        capture(0, 0, 0, fv, dn, h3);
        chk("tmo_first_valid", fv, TO + 1);
        chk("tmo_idle_data", acc_d[5], 0);
        chk("tmo_idle_ovf", acc_o[5], 0);
        chk("tmo_other", acc_d[0], 4);

        setall(1, 3);
        for (int k = 0; k < ST; k++) wid[k] = k + 2;
        capture(2, 0, 0, fv, dn, h3);
        chk("stall_held", h3, 6);
        chk("stall_words", acc_n, 8);
        chk("stall_done", dn, 1);

        setall(1, 2);
        dly[0] = 0; wid[0] = 7; dly2[0] = 12; wid2[0] = 3;
        capture(0, 0, 0, fv, dn, h3);
        chk("armed_high", acc_d[0], 6);

        setall(1, 9);
        capture(0, 1, 1, fv, dn, h3);
        chk("abort_no_done", dn, 0);
        setall(3, 6);
        capture(0, 1, 0, fv, dn, h3);
        chk("after_abort_done", dn, 1);
        chk("after_abort_data", acc_d[7], 6);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < ST; k++) begin
                dly[k]  = $urandom_range(0, 15);
                wid[k]  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
                dly2[k] = dly[k] + wid[k] + $urandom_range(1, 10);
                wid2[k] = $urandom_range(0, 20);
            end
            capture(1, 1'($urandom_range(0, 1)), 0, fv, dn, h3);
            chk("rand_done", dn, 1);
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
